// File: rtl/pwm_corriente_pkg.sv
// Shared constants, types and the index-to-compare-value helper for the current PWM generator.
package pwm_corriente_pkg;

   localparam int PERIOD    = 1000;
   localparam int STEP      = 20;
   localparam int MAX_IDX   = 50;
   localparam int RESET_IDX = 25;

   typedef logic [5:0] idx_t;
   typedef logic [9:0] cnt_t;

   // Ten bits suffice: the index is clamped to MAX_IDX before it gets here, so the peak is 1000.
   function automatic cnt_t idx_a_numero(input idx_t idx);
      return cnt_t'(idx) * cnt_t'(STEP);
   endfunction

endpackage

// File: rtl/generador_pwm_corriente_if.sv
// Control/status bundle between the control logic (master) and the PWM generator (slave).
interface generador_pwm_corriente_if;
   import pwm_corriente_pkg::*;

   idx_t indice;
   logic cargar;
   logic pwm;
   cnt_t numero;
   logic en_objetivo;
   logic fin_periodo;
   logic fuera_rango;

   modport master (
      output indice, cargar,
      input  pwm, numero, en_objetivo, fin_periodo, fuera_rango
   );

   modport slave (
      input  indice, cargar,
      output pwm, numero, en_objetivo, fin_periodo, fuera_rango
   );

endinterface

// File: rtl/divisor_tick.sv
// Prescaler: asserts tick once every PRESCALE clocks (continuously when PRESCALE is 1).
module divisor_tick #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [W-1:0] r_presc;

   assign tick = (r_presc == W'(PRESCALE - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
      end else if (tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + W'(1);
      end
   end

endmodule

// File: rtl/generador_pwm_corriente.sv
// Duty-index driven PWM for the current driver; duty changes only at period wrap.
// Define PWM_RAMP_EN to step the applied index one unit per period toward the target.
module generador_pwm_corriente
   import pwm_corriente_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   generador_pwm_corriente_if.slave      bus
);

   logic w_tick;
   logic w_wrap;
   logic w_fuera;
   idx_t w_indice_lim;
   idx_t w_idx_paso;
   idx_t w_idx_next;
   idx_t w_target_next;

   cnt_t r_cnt;
   cnt_t r_numero;
   idx_t r_idx;
   idx_t r_target;
   logic r_pwm;
   logic r_en;
   logic r_fin;
   logic r_fuera;

   divisor_tick #(.PRESCALE(PRESCALE)) u_divisor (
      .clk   (clk),
      .reset (reset),
      .tick  (w_tick)
   );

   assign w_wrap       = w_tick && (r_cnt == cnt_t'(PERIOD - 1));
   assign w_fuera      = bus.cargar && (bus.indice > idx_t'(MAX_IDX));
   assign w_indice_lim = w_fuera ? idx_t'(MAX_IDX) : bus.indice;

`ifdef PWM_RAMP_EN
   always_comb begin
      w_idx_paso = r_idx;
      if (r_idx < r_target) begin
         w_idx_paso = r_idx + idx_t'(1);
      end else if (r_idx > r_target) begin
         w_idx_paso = r_idx - idx_t'(1);
      end
   end
`else
   assign w_idx_paso = r_target;
`endif

   // The wrap reads r_target before any coincident load lands, so a load on the wrap clock waits a period.
   assign w_idx_next    = w_wrap ? w_idx_paso : r_idx;
   assign w_target_next = bus.cargar ? w_indice_lim : r_target;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_idx    <= idx_t'(RESET_IDX);
         r_target <= idx_t'(RESET_IDX);
         r_numero <= idx_a_numero(idx_t'(RESET_IDX));
         r_pwm    <= 1'b0;
         r_en     <= 1'b1;
         r_fin    <= 1'b0;
         r_fuera  <= 1'b0;
      end else begin
         if (w_tick) begin
            r_cnt <= w_wrap ? '0 : r_cnt + cnt_t'(1);
         end
         if (w_wrap) begin
            r_numero <= idx_a_numero(w_idx_paso);
         end
         r_idx    <= w_idx_next;
         r_target <= w_target_next;
         r_pwm    <= (r_cnt < r_numero);
         r_en     <= (w_idx_next == w_target_next);
         r_fin    <= w_wrap;
         r_fuera  <= w_fuera;
      end
   end

   assign bus.pwm         = r_pwm;
   assign bus.numero      = r_numero;
   assign bus.en_objetivo = r_en;
   assign bus.fin_periodo = r_fin;
   assign bus.fuera_rango = r_fuera;

endmodule

// File: tb/tb_generador_pwm_corriente.sv
// Bench for generador_pwm_corriente: each period's expected compare value is queued when the
// preceding period (and its load) is modelled, then popped and checked against the measured period.
module tb_generador_pwm_corriente;
   import pwm_corriente_pkg::*;

   logic clk = 1'b0;
   logic reset;

   generador_pwm_corriente_if bus ();

   generador_pwm_corriente #(.PRESCALE(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int m_idx;
   int m_target;

   function automatic int paso(input int idx, input int tgt);
`ifdef PWM_RAMP_EN
      if (idx < tgt) return idx + 1;
      if (idx > tgt) return idx - 1;
      return idx;
`else
      return tgt;
`endif
   endfunction

   // One full period starting at the sample where the previous wrap (or reset release) is visible.
   task automatic run_period(input int load_at, input int val, input string nombre);
      int exp_num;
      int high;
      int fin_bad;
      int fuera_bad;
      int en_bad;
      bit has_load;
      has_load = (load_at >= 0);
      high = 0; fin_bad = 0; fuera_bad = 0; en_bad = 0;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s sb_empty: no expected value queued", nombre);
         exp_num = -1;
      end else begin
         exp_num = exp_q.pop_front();
      end
      checks++;
      if (bus.numero !== 10'(exp_num)) begin
         errors++;
         $display("FAIL %s numero: got %0d expected %0d", nombre, bus.numero, exp_num);
      end
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         if (bus.pwm === 1'b1) high++;
         if (bus.fin_periodo !== (i == PERIOD - 1)) fin_bad++;
         if (i == PERIOD - 1) m_idx = paso(m_idx, m_target);
         if (has_load && i == load_at + 1) m_target = (val > MAX_IDX) ? MAX_IDX : val;
         if (bus.fuera_rango !== (has_load && i == load_at + 1 && val > MAX_IDX)) fuera_bad++;
         if (bus.en_objetivo !== (m_idx == m_target)) begin
            if (en_bad == 0)
               $display("FAIL %s en_objetivo at sample %0d: got %b expected %b",
                        nombre, i, bus.en_objetivo, (m_idx == m_target));
            en_bad++;
         end
         if (has_load && i == load_at) begin
            bus.cargar = 1'b1;
            bus.indice = 6'(val);
         end else begin
            bus.cargar = 1'b0;
            bus.indice = 6'($urandom_range(0, 63));
         end
      end
      checks++;
      if (high !== exp_num) begin
         errors++;
         $display("FAIL %s high_time: got %0d expected %0d", nombre, high, exp_num);
      end
      checks++;
      if (fin_bad !== 0) begin
         errors++;
         $display("FAIL %s fin_periodo: got %0d bad samples expected 0", nombre, fin_bad);
      end
      checks++;
      if (fuera_bad !== 0) begin
         errors++;
         $display("FAIL %s fuera_rango: got %0d bad samples expected 0", nombre, fuera_bad);
      end
      checks++;
      if (en_bad !== 0) errors++;
      exp_q.push_back(m_idx * STEP);
      $display("periodo %s: numero_esperado=%0d alto=%0d carga=%0d", nombre, exp_num, high,
               has_load ? val : -1);
   endtask

   task automatic check_reset_values(input string nombre);
      checks++;
      if (bus.pwm !== 1'b0) begin
         errors++; $display("FAIL %s pwm: got %b expected 0", nombre, bus.pwm);
      end
      checks++;
      if (bus.numero !== 10'd500) begin
         errors++; $display("FAIL %s numero: got %0d expected 500", nombre, bus.numero);
      end
      checks++;
      if (bus.en_objetivo !== 1'b1) begin
         errors++; $display("FAIL %s en_objetivo: got %b expected 1", nombre, bus.en_objetivo);
      end
      checks++;
      if (bus.fin_periodo !== 1'b0) begin
         errors++; $display("FAIL %s fin_periodo: got %b expected 0", nombre, bus.fin_periodo);
      end
      checks++;
      if (bus.fuera_rango !== 1'b0) begin
         errors++; $display("FAIL %s fuera_rango: got %b expected 0", nombre, bus.fuera_rango);
      end
      $display("reset %s: pwm=%b numero=%0d en=%b", nombre, bus.pwm, bus.numero, bus.en_objetivo);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
      m_idx = RESET_IDX;
      m_target = RESET_IDX;
      exp_q.delete();
      exp_q.push_back(RESET_IDX * STEP);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.cargar = 1'b1;
      bus.indice = 6'd7;
      repeat (3) @(negedge clk);
      check_reset_values("inicial");
      bus.cargar = 1'b0;
      release_reset();
      run_period(-1, 0, "reset_p1");
      run_period(-1, 0, "reset_p2");
   endtask

   task automatic test_carga_10();
      run_period(300, 10, "carga10_a");
      run_period(-1, 0, "carga10_b");
      run_period(-1, 0, "carga10_c");
   endtask

   task automatic test_extremos();
      run_period(100, 0, "extremo_a");
      run_period(100, 50, "extremo_cero");
      run_period(-1, 0, "extremo_lleno_a");
      run_period(-1, 0, "extremo_lleno_b");
   endtask

   task automatic test_fuera_rango();
      run_period(50, 5, "fuera_a");
      run_period(50, 63, "fuera_b");
      run_period(-1, 0, "fuera_c");
   endtask

   task automatic test_carga_en_wrap();
      run_period(PERIOD - 2, 10, "wrap_a");
      run_period(-1, 0, "wrap_b");
      run_period(-1, 0, "wrap_c");
   endtask

   task automatic test_reset_async(input string nombre);
      repeat (100) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_reset_values(nombre);
      release_reset();
      run_period(-1, 0, {nombre, "_post"});
   endtask

   task automatic test_rampa();
      run_period(100, 30, "rampa_carga");
      for (int k = 0; k < 5; k++) run_period(-1, 0, $sformatf("rampa_%0d", k));
      run_period(100, 20, "rampa_baja");
      run_period(-1, 0, "rampa_baja_b");
      test_reset_async("rampa_reset");
   endtask

   initial begin
      bus.cargar = 1'b0;
      bus.indice = '0;
      test_reset();
      test_carga_10();
      test_extremos();
      test_fuera_rango();
      test_carga_en_wrap();
      test_reset_async("async");
      test_rampa();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
